// File: rtl/pwm_channel_bank.sv
// pwm_channel_bank: NUM_CH PWM compare channels sharing one prescaler and
// one period counter. Configuration is captured into a shadow set on
// update_req and moved to the active set either immediately (while idle)
// or at the next period wrap (while running), so a period never mixes
// old and new settings.
// Optional feature macro: PWM_BANK_CYCLE_COUNT_EN adds the cycle_count port
// and its completed-period counter.
module pwm_channel_bank #(
    parameter int NUM_CH = 16,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    run,
    input  logic [CNT_W-1:0]        period,
    input  logic [CNT_W-1:0]        prescale,
    input  logic [NUM_CH*CNT_W-1:0] duty,
    input  logic [NUM_CH-1:0]       polarity,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic                    update_req,
    output logic                    update_pending,
    output logic                    update_ack,
    output logic [NUM_CH-1:0]       pwm_out,
    output logic                    period_start
`ifdef PWM_BANK_CYCLE_COUNT_EN
    ,
    output logic [31:0]             cycle_count
`endif
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          pre_cnt_q, pre_cnt_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    // active set
    logic [CNT_W-1:0]          period_a_q, period_a_d;
    logic [CNT_W-1:0]          prescale_a_q, prescale_a_d;
    logic [NUM_CH*CNT_W-1:0]   duty_a_q, duty_a_d;
    logic [NUM_CH-1:0]         pol_a_q, pol_a_d;
    logic [NUM_CH-1:0]         en_a_q, en_a_d;
    // shadow set
    logic [CNT_W-1:0]          period_s_q, period_s_d;
    logic [CNT_W-1:0]          prescale_s_q, prescale_s_d;
    logic [NUM_CH*CNT_W-1:0]   duty_s_q, duty_s_d;
    logic [NUM_CH-1:0]         pol_s_q, pol_s_d;
    logic [NUM_CH-1:0]         en_s_q, en_s_d;
    // handshake and outputs
    logic                      pending_q, pending_d;
    logic                      ack_q, ack_d;
    logic [NUM_CH-1:0]         pwm_q, pwm_d;
    logic                      pstart_q, pstart_d;

    logic                      tick_s;
    logic                      wrap_s;
    logic                      apply_s;
    logic [NUM_CH-1:0]         raw_s;

    // Counter sequencing, shadow/active transfer and per-channel compare.
    always_comb begin
        state_d      = state_q;
        pre_cnt_d    = pre_cnt_q;
        cnt_d        = cnt_q;
        period_a_d   = period_a_q;
        prescale_a_d = prescale_a_q;
        duty_a_d     = duty_a_q;
        pol_a_d      = pol_a_q;
        en_a_d       = en_a_q;
        period_s_d   = period_s_q;
        prescale_s_d = prescale_s_q;
        duty_s_d     = duty_s_q;
        pol_s_d      = pol_s_q;
        en_s_d       = en_s_q;
        pending_d    = pending_q;
        ack_d        = 1'b0;
        pwm_d        = pwm_q;
        pstart_d     = 1'b0;
        raw_s        = '0;

        tick_s  = (state_q == ST_RUN) && (pre_cnt_q == prescale_a_q);
        wrap_s  = tick_s && (cnt_q == period_a_q);
        // While idle there is no period to protect, so apply right away.
        apply_s = pending_q && ((state_q == ST_IDLE) || wrap_s);

        case (state_q)
            ST_IDLE: state_d = run ? ST_RUN : ST_IDLE;
            ST_RUN:  state_d = run ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Counters only advance while running and staying in RUN; leaving
        // RUN parks them at zero so the next start begins a fresh period.
        if ((state_q == ST_RUN) && run) begin
            if (tick_s) begin
                pre_cnt_d = '0;
                cnt_d     = wrap_s ? '0 : cnt_q + CNT_W'(1);
            end else begin
                pre_cnt_d = pre_cnt_q + CNT_W'(1);
                cnt_d     = cnt_q;
            end
        end else begin
            pre_cnt_d = '0;
            cnt_d     = '0;
        end

        if (apply_s) begin
            period_a_d   = period_s_q;
            prescale_a_d = prescale_s_q;
            duty_a_d     = duty_s_q;
            pol_a_d      = pol_s_q;
            en_a_d       = en_s_q;
            ack_d        = 1'b1;
        end else begin
            ack_d        = 1'b0;
        end

        // A request on the applying edge refills the shadow and keeps the
        // pending flag set, so it is applied at the following opportunity.
        if (update_req) begin
            period_s_d   = period;
            prescale_s_d = prescale;
            duty_s_d     = duty;
            pol_s_d      = polarity;
            en_s_d       = ch_en;
            pending_d    = 1'b1;
        end else if (apply_s) begin
            pending_d    = 1'b0;
        end else begin
            pending_d    = pending_q;
        end

        // duty > period gives 100 % because cnt never exceeds period.
        for (int i = 0; i < NUM_CH; i++) begin
            raw_s[i] = en_a_q[i] && (cnt_q < duty_a_q[i*CNT_W +: CNT_W]);
        end

        if (state_q == ST_RUN) begin
            pwm_d    = raw_s ^ pol_a_q;
            pstart_d = (cnt_q == '0) && (pre_cnt_q == '0);
        end else begin
            pwm_d    = pol_a_q;
            pstart_d = 1'b0;
        end
    end

    // State, counters, register sets and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pre_cnt_q    <= '0;
            cnt_q        <= '0;
            period_a_q   <= '0;
            prescale_a_q <= '0;
            duty_a_q     <= '0;
            pol_a_q      <= '0;
            en_a_q       <= '0;
            period_s_q   <= '0;
            prescale_s_q <= '0;
            duty_s_q     <= '0;
            pol_s_q      <= '0;
            en_s_q       <= '0;
            pending_q    <= 1'b0;
            ack_q        <= 1'b0;
            pwm_q        <= '0;
            pstart_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pre_cnt_q    <= pre_cnt_d;
            cnt_q        <= cnt_d;
            period_a_q   <= period_a_d;
            prescale_a_q <= prescale_a_d;
            duty_a_q     <= duty_a_d;
            pol_a_q      <= pol_a_d;
            en_a_q       <= en_a_d;
            period_s_q   <= period_s_d;
            prescale_s_q <= prescale_s_d;
            duty_s_q     <= duty_s_d;
            pol_s_q      <= pol_s_d;
            en_s_q       <= en_s_d;
            pending_q    <= pending_d;
            ack_q        <= ack_d;
            pwm_q        <= pwm_d;
            pstart_q     <= pstart_d;
        end
    end

    assign update_pending = pending_q;
    assign update_ack     = ack_q;
    assign pwm_out        = pwm_q;
    assign period_start   = pstart_q;

`ifdef PWM_BANK_CYCLE_COUNT_EN
    logic [31:0] cyc_q, cyc_d;

    // Completed-period count: one per wrap, free-running modulo 2^32.
    always_comb begin
        cyc_d = cyc_q;
        if (wrap_s) begin
            cyc_d = cyc_q + 32'd1;
        end else begin
            cyc_d = cyc_q;
        end
    end

    // Completed-period counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_q <= 32'd0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

    assign cycle_count = cyc_q;
`endif

endmodule
